// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared state encoding, requester ids and latency bound for the memory port arbiter
package proc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_DATA  = 1'b1;

    localparam int LAT_MAX = 4;
    localparam int CNT_W   = $clog2(LAT_MAX);

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - combinational two-way round-robin pick (bit 0 = fetch, bit 1 = data)
module rr_arbiter_2
    import proc_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] gnt_o,
    output logic       winner_o
);

    always_comb begin
        winner_o = REQ_FETCH;
        gnt_o    = 2'b00;
        case (req_i)
            2'b01:   winner_o = REQ_FETCH;
            2'b10:   winner_o = REQ_DATA;
            // On a tie the side that did not win last time goes first.
            2'b11:   winner_o = ~last_grant_i;
            default: winner_o = REQ_FETCH;
        endcase
        if (|req_i) begin
            gnt_o = (winner_o == REQ_DATA) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between instruction fetch and data access
module mem_port_arbiter
    import proc_pkg::*;
#(
    parameter int AW  = 10,
    parameter int DW  = 32,
    parameter int LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic              txn_we_q, txn_we_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
    logic              if_gnt_q, if_gnt_d;
    logic              d_gnt_q, d_gnt_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [DW-1:0]     if_rdata_q, if_rdata_d;
    logic [DW-1:0]     d_rdata_q, d_rdata_d;
    logic              busy_q, busy_d;

    logic [1:0]        pick_gnt;
    logic              pick_winner;

    rr_arbiter_2 u_rr (
        .req_i        ({d_req, if_req}),
        .last_grant_i (last_grant_q),
        .gnt_o        (pick_gnt),
        .winner_o     (pick_winner)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        txn_we_d     = txn_we_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_gnt_d     = 1'b0;
        d_gnt_d      = 1'b0;
        if_ack_d     = 1'b0;
        d_ack_d      = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (|pick_gnt) begin
                    owner_d      = pick_winner;
                    last_grant_d = pick_winner;
                    mem_en_d     = 1'b1;
                    state_d      = ST_ISSUE;
                    if (pick_winner == REQ_DATA) begin
                        mem_addr_d  = d_addr;
                        mem_we_d    = d_we;
                        mem_wdata_d = d_wdata;
                        txn_we_d    = d_we;
                        d_gnt_d     = 1'b1;
                    end else begin
                        mem_addr_d  = if_addr;
                        txn_we_d    = 1'b0;
                        if_gnt_d    = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d   = CNT_INIT;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    if (owner_q == REQ_DATA) begin
                        d_ack_d = 1'b1;
                        // Writes leave the last loaded word untouched.
                        if (!txn_we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= REQ_FETCH;
            owner_q      <= REQ_FETCH;
            txn_we_q     <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_gnt_q     <= 1'b0;
            d_gnt_q      <= 1'b0;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            txn_we_q     <= txn_we_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_gnt_q     <= if_gnt_d;
            d_gnt_q      <= d_gnt_d;
            if_ack_q     <= if_ack_d;
            d_ack_q      <= d_ack_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign if_ack    = if_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_gnt     = d_gnt_q;
    assign d_ack     = d_ack_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench over three arbiter lanes with LAT = 1, 2 and 4
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;

    logic        if_req    [3];
    logic [9:0]  if_addr   [3];
    logic        if_gnt    [3];
    logic        if_ack    [3];
    logic [31:0] if_rdata  [3];
    logic        d_req     [3];
    logic        d_we      [3];
    logic [9:0]  d_addr    [3];
    logic [31:0] d_wdata   [3];
    logic        d_gnt     [3];
    logic        d_ack     [3];
    logic [31:0] d_rdata   [3];
    logic        mem_en    [3];
    logic        mem_we    [3];
    logic [9:0]  mem_addr  [3];
    logic [31:0] mem_wdata [3];
    logic [31:0] mem_rdata [3];
    logic        busy      [3];

    int compared;
    int mismatched;

    function automatic logic [31:0] f(input logic [9:0] a);
        if (a == 10'h004) return 32'hDEADBEEF;
        return {a, 2'b01, ~a, a};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 3; g++) begin : g_lane
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 4);

        logic [31:0] mem [1024];
        logic [9:0]  rd_addr;
        int          rd_cnt;

        initial begin
            for (int a = 0; a < 1024; a++) mem[a] = f(10'(a));
            rd_addr = '0;
            rd_cnt  = 0;
        end

        always @(posedge clk) begin
            if (rd_cnt > 0) rd_cnt <= rd_cnt - 1;
            if (mem_en[g]) begin
                if (mem_we[g]) mem[mem_addr[g]] <= mem_wdata[g];
                else begin
                    rd_addr <= mem_addr[g];
                    rd_cnt  <= L;
                end
            end
        end

        // Read data is only valid on the single edge the arbiter should sample it.
        assign mem_rdata[g] = (rd_cnt == 1) ? mem[rd_addr] : 32'hBAD0BAD0;

        mem_port_arbiter #(.AW(10), .DW(32), .LAT(L)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .if_req    (if_req[g]),
            .if_addr   (if_addr[g]),
            .if_gnt    (if_gnt[g]),
            .if_ack    (if_ack[g]),
            .if_rdata  (if_rdata[g]),
            .d_req     (d_req[g]),
            .d_we      (d_we[g]),
            .d_addr    (d_addr[g]),
            .d_wdata   (d_wdata[g]),
            .d_gnt     (d_gnt[g]),
            .d_ack     (d_ack[g]),
            .d_rdata   (d_rdata[g]),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g]),
            .busy      (busy[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic        win_d;
        logic [9:0]  sweep [8];
        compared   = 0;
        mismatched = 0;
        sweep = '{10'h000, 10'h001, 10'h07F, 10'h155, 10'h2AA, 10'h3FE, 10'h3FF, 10'h200};

        rst_n = 1'b0;
        for (int l = 0; l < 3; l++) begin
            if_req[l] = 1'b0; if_addr[l] = '0;
            d_req[l]  = 1'b0; d_we[l]    = 1'b0; d_addr[l] = '0; d_wdata[l] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int l = 0; l < 3; l++) begin
            chk("rst_busy",   busy[l], 0);
            chk("rst_mem_en", mem_en[l], 0);
            chk("rst_gnt",    if_gnt[l] | d_gnt[l], 0);
            chk("rst_ack",    if_ack[l] | d_ack[l], 0);
            chk("rst_rdata",  if_rdata[l] | d_rdata[l], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Single fetch, LAT=1
        if_req[0] = 1'b1; if_addr[0] = 10'h004;
        tick();
        chk("f1_gnt", if_gnt[0], 1);
        chk("f1_en", mem_en[0], 1);
        chk("f1_we", mem_we[0], 0);
        chk("f1_addr", mem_addr[0], 10'h004);
        chk("f1_busy", busy[0], 1);
        if_req[0] = 1'b0;
        tick();
        chk("f1_gnt_off", if_gnt[0], 0);
        chk("f1_en_off", mem_en[0], 0);
        chk("f1_ack_early", if_ack[0], 0);
        tick();
        chk("f1_ack", if_ack[0], 1);
        chk("f1_rdata", if_rdata[0], 32'hDEADBEEF);
        tick();
        chk("f1_ack_pulse", if_ack[0], 0);
        chk("f1_busy_after", busy[0], 0);
        chk("f1_rdata_hold", if_rdata[0], 32'hDEADBEEF);

        // Data write then read, LAT=2
        d_req[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = 10'h3F0; d_wdata[1] = 32'h12345678;
        tick();
        chk("w_gnt", d_gnt[1], 1);
        chk("w_we_issue", mem_we[1], 1);
        chk("w_wdata", mem_wdata[1], 32'h12345678);
        d_req[1] = 1'b0; d_we[1] = 1'b0;
        tick();
        chk("w_we_wait", mem_we[1], 0);
        chk("w_en_wait", mem_en[1], 0);
        tick();
        chk("w_ack_early", d_ack[1], 0);
        tick();
        chk("w_ack", d_ack[1], 1);
        chk("w_rdata_kept", d_rdata[1], 0);
        chk("w_addr_hold", mem_addr[1], 10'h3F0);
        d_req[1] = 1'b1;
        tick();
        chk("r_gnt", d_gnt[1], 1);
        chk("r_we", mem_we[1], 0);
        d_req[1] = 1'b0;
        repeat (2) tick();
        tick();
        chk("r_ack", d_ack[1], 1);
        chk("r_rdata", d_rdata[1], 32'h12345678);

        // Tie after reset on LAT=4 lane: D, F, D, F spaced 6 cycles apart
        if_req[2] = 1'b1; if_addr[2] = 10'h010;
        d_req[2]  = 1'b1; d_addr[2]  = 10'h020; d_we[2] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            win_d = ((k % 2) == 0);
            tick();
            chk("tie_dgnt", d_gnt[2], win_d);
            chk("tie_fgnt", if_gnt[2], !win_d);
            chk("tie_addr", mem_addr[2], win_d ? 10'h020 : 10'h010);
            for (int c = 0; c < 4; c++) begin
                tick();
                chk("tie_quiet", if_gnt[2] | d_gnt[2] | if_ack[2] | d_ack[2], 0);
            end
            tick();
            chk("tie_ack", win_d ? d_ack[2] : if_ack[2], 1);
            chk("tie_ack_excl", if_ack[2] & d_ack[2], 0);
            chk("tie_rdata", win_d ? d_rdata[2] : if_rdata[2], win_d ? f(10'h020) : f(10'h010));
            if (k == 3) begin
                if_req[2] = 1'b0; d_req[2] = 1'b0;
            end
        end
        tick();
        chk("tie_done", busy[2] | if_gnt[2] | d_gnt[2], 0);

        // Data request arriving during a fetch's WAIT, LAT=1
        if_req[0] = 1'b1; if_addr[0] = 10'h008;
        tick();
        chk("wt_fgnt", if_gnt[0], 1);
        if_req[0] = 1'b0;
        tick();
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 10'h030;
        tick();
        chk("wt_fack", if_ack[0], 1);
        chk("wt_no_dgnt", d_gnt[0], 0);
        tick();
        chk("wt_dgnt", d_gnt[0], 1);
        d_req[0] = 1'b0;
        repeat (2) tick();
        chk("wt_dack", d_ack[0], 1);
        chk("wt_drdata", d_rdata[0], f(10'h030));

        // Reset mid-transaction on lanes 0 and 1
        if_req[0] = 1'b1; if_addr[0] = 10'h00C;
        d_req[1]  = 1'b1; d_we[1]    = 1'b0; d_addr[1] = 10'h040;
        tick();
        chk("mr_fgnt", if_gnt[0], 1);
        chk("mr_dgnt", d_gnt[1], 1);
        if_req[0] = 1'b0; d_req[1] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mr_en0", mem_en[0], 0);
        chk("mr_gnt0", if_gnt[0], 0);
        chk("mr_busy0", busy[0], 0);
        chk("mr_en1", mem_en[1], 0);
        chk("mr_gnt1", d_gnt[1], 0);
        chk("mr_rdata0", if_rdata[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("mr_no_ack", if_ack[0] | d_ack[0] | if_ack[1] | d_ack[1], 0);
        end
        if_req[1] = 1'b1; if_addr[1] = 10'h050;
        d_req[1]  = 1'b1; d_addr[1]  = 10'h060;
        tick();
        chk("mr_tie_d", d_gnt[1], 1);
        chk("mr_tie_f", if_gnt[1], 0);
        d_req[1] = 1'b0;
        repeat (2) tick();
        tick();
        chk("mr_dack", d_ack[1], 1);
        chk("mr_drdata", d_rdata[1], f(10'h060));
        tick();
        chk("mr_pending_f", if_gnt[1], 1);
        if_req[1] = 1'b0;
        repeat (2) tick();
        tick();
        chk("mr_fack", if_ack[1], 1);
        chk("mr_frdata", if_rdata[1], f(10'h050));

        // LAT=4 back-to-back fetch sweep
        if_req[2] = 1'b1; if_addr[2] = sweep[0];
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("sw_gnt", if_gnt[2], 1);
            chk("sw_addr", mem_addr[2], sweep[k]);
            for (int c = 0; c < 4; c++) begin
                tick();
                chk("sw_quiet", if_ack[2] | if_gnt[2], 0);
            end
            tick();
            chk("sw_ack", if_ack[2], 1);
            chk("sw_rdata", if_rdata[2], f(sweep[k]));
            if (k == 7) if_req[2] = 1'b0;
            else        if_addr[2] = sweep[k + 1];
        end
        tick();
        chk("sw_idle", busy[2] | if_gnt[2], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified memory between the instruction-fetch requester (control unit fetch state) and the data requester (load/store/push/pop) of the multicycle processor.
- Accepts one transaction at a time and arbitrates round-robin when both requesters are pending.
- Drives the memory enable, write-enable, address and write-data lines, then waits a fixed read latency.
- Returns read data and a completion pulse to the requester that won.

Parameters:
- AW, 10, address width (word-addressed).
- DW, 32, data width.
- LAT, 1, memory read latency in cycles, counted from the edge that samples mem_en; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request (level); sampled only in IDLE.
- if_addr  in  AW  fetch address.
- if_gnt  out  1  one-cycle pulse: fetch accepted.
- if_ack  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DW  fetched word; holds until the next fetch ack.
- d_req  in  1  data request (level); sampled only in IDLE.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_gnt  out  1  one-cycle pulse: data access accepted.
- d_ack  out  1  one-cycle pulse: access complete; d_rdata valid if read.
- d_rdata  out  DW  loaded word; holds until the next data read ack.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid LAT cycles after the edge sampling mem_en.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
Reset:
- All outputs are 0, state = IDLE, latency counter = 0.
- last_grant = FETCH, so the data requester wins the first tie.
- Reset is asynchronous. Asserting it mid-transaction drops the transaction, immediately clears mem_en and mem_we, and issues no ack.

States: IDLE -> ISSUE -> WAIT -> IDLE. All outputs are registered.

IDLE:
- At edge E0, if any request is high, select the winner:
  - If only one requester is pending, it wins.
  - If both are pending, the requester not equal to last_grant wins.
- Latch the winner's address, we and wdata into the mem_* registers.
- Update last_grant and go to ISSUE.
- Fetch always has mem_we = 0.

ISSUE (the one cycle after E0):
- mem_en = 1 and the winner's gnt = 1.
- At edge E1: mem_en and mem_we return to 0, counter = LAT-1, go to WAIT.

WAIT:
- Decrement the counter each edge.
- At the edge where the counter is 0 (edge E(1+LAT)):
  - Capture mem_rdata into the winner's rdata register; skip the capture for data writes.
  - Pulse the winner's ack for one cycle and go to IDLE.

Timing:
- gnt appears 1 cycle after request sampling.
- ack appears LAT+1 cycles after gnt.
- Minimum request-to-request period is LAT+2 cycles.

Requester rules:
- Address, we and wdata only need to be valid at the sampling edge.
- A requester wanting no further access must drop req no later than the cycle its ack is high. If req is still high in IDLE, it is a new request.

Other rules:
- The non-winning request is held pending, and is neither granted nor lost.
- The mem_* address and data lines hold their last values when idle. Only mem_en and mem_we are forced low.
- Only one gnt and one ack are high in any cycle.

Decomposition:
- Shared package (proc_pkg): state encoding constants (IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2), requester ids (REQ_FETCH = 1'b0, REQ_DATA = 1'b1), and the LAT_MAX = 4 bound used for counter width.
- Sub-module rr_arbiter_2: combinational 2-way round-robin pick from (req[1:0], last_grant), returning a one-hot grant and winner id.

Test Plan:
- Single fetch, LAT=1, mem holds 0xDEADBEEF at addr 0x004:
  - if_req=1 in IDLE -> mem_en=1, mem_addr=0x004, if_gnt=1 one cycle later.
  - if_ack=1 with if_rdata=0xDEADBEEF 2 cycles after if_gnt.
  - busy low the cycle after ack.
- Data write then read, LAT=2:
  - Write 0x12345678 to addr 0x3F0 -> mem_we=1 only in the ISSUE cycle, d_ack 3 cycles after d_gnt, d_rdata unchanged.
  - Read of 0x3F0 -> d_rdata=0x12345678.
- Simultaneous requests after reset, both held continuously:
  - Grants alternate D, F, D, F over 4 transactions.
  - Each grant is spaced LAT+2 cycles apart.
  - if_ack and d_ack are never high together.
- Request arriving during WAIT:
  - d_req rises during a fetch's WAIT -> not granted until IDLE.
  - d_gnt appears exactly 1 cycle after the fetch's if_ack cycle.
- Reset mid-transaction:
  - rst_n low during ISSUE -> mem_en, if_gnt and busy go to 0 without a clock edge.
  - No ack is issued after reset release.
  - The next tie goes to data.
- LAT=4 sweep with back-to-back single fetches at 8 addresses:
  - Every if_ack occurs exactly 5 cycles after its if_gnt.
  - The captured data matches the memory model.
